// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the two-leader bus arbiter.
package bus_arbiter_pkg;

    typedef enum logic {
        IDLE      = 1'b0,
        READ_WAIT = 1'b1
    } arb_state_t;

    typedef logic        leader_id_t;
    typedef logic [31:0] word_t;

    // Returned to the owner when a follower never answers a read.
    localparam word_t ErrorData = 32'hDEAD_BEEF;

endpackage

// File: rtl/bus_arbiter_if.sv
// Simple single-outstanding-read bus: a leader drives the request, a follower answers reads.
interface system_bus;
    import bus_arbiter_pkg::*;

    word_t       addr;
    logic        read_req;
    logic        write_req;
    logic [3:0]  byte_enable;
    word_t       write_data;
    word_t       read_data;
    logic        read_data_valid;

    modport leader (
        output addr, read_req, write_req, byte_enable, write_data,
        input  read_data, read_data_valid
    );

    modport follower (
        input  addr, read_req, write_req, byte_enable, write_data,
        output read_data, read_data_valid
    );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Combinational two-way round-robin picker; on a tie the side not granted last wins.
module rr_arbiter2
    import bus_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  leader_id_t last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = (last_grant == 1'b1) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one bus leader port between two requesters, routing the single outstanding
// read response back to its owner and forcing an error response on timeout.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int TimeoutCycles = 16
) (
    input  logic        clk,
    input  logic        reset,
    system_bus.follower leader0,
    system_bus.follower leader1,
    system_bus.leader   out,
    output logic        accept0,
    output logic        accept1,
    output logic        timeout
);

    localparam logic [7:0] TimeoutLast = 8'(TimeoutCycles - 1);

    arb_state_t state_q;
    leader_id_t last_grant_q;
    leader_id_t owner_q;
    logic [7:0] count_q;
    logic       timeout_q;

    logic [1:0] req;
    logic [1:0] grant;
    logic       win_read;
    logic       timeout_hit;
    logic       rsp_valid;
    word_t      rsp_data;

    assign req = {leader1.read_req | leader1.write_req,
                  leader0.read_req | leader0.write_req};

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        out.addr                = '0;
        out.read_req            = 1'b0;
        out.write_req           = 1'b0;
        out.byte_enable         = '0;
        out.write_data          = '0;
        accept0                 = 1'b0;
        accept1                 = 1'b0;
        leader0.read_data       = '0;
        leader0.read_data_valid = 1'b0;
        leader1.read_data       = '0;
        leader1.read_data_valid = 1'b0;
        win_read                = 1'b0;
        timeout_hit             = 1'b0;
        rsp_valid               = 1'b0;
        rsp_data                = '0;

        if (state_q == IDLE) begin
            if (grant[0]) begin
                out.addr        = leader0.addr;
                out.read_req    = leader0.read_req;
                out.write_req   = leader0.write_req;
                out.byte_enable = leader0.byte_enable;
                out.write_data  = leader0.write_data;
                accept0         = 1'b1;
                win_read        = leader0.read_req;
            end else if (grant[1]) begin
                out.addr        = leader1.addr;
                out.read_req    = leader1.read_req;
                out.write_req   = leader1.write_req;
                out.byte_enable = leader1.byte_enable;
                out.write_data  = leader1.write_data;
                accept1         = 1'b1;
                win_read        = leader1.read_req;
            end
        end else begin
            // A real response always beats the timeout in the same cycle.
            timeout_hit = !out.read_data_valid && (count_q == TimeoutLast);
            rsp_valid   = out.read_data_valid | timeout_hit;
            rsp_data    = out.read_data_valid ? out.read_data : ErrorData;
            if (rsp_valid) begin
                if (owner_q == 1'b0) begin
                    leader0.read_data       = rsp_data;
                    leader0.read_data_valid = 1'b1;
                end else begin
                    leader1.read_data       = rsp_data;
                    leader1.read_data_valid = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            count_q      <= '0;
            timeout_q    <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept0 || accept1) begin
                        last_grant_q <= leader_id_t'(accept1);
                        if (win_read) begin
                            owner_q <= leader_id_t'(accept1);
                            count_q <= '0;
                            state_q <= READ_WAIT;
                        end
                    end
                end
                READ_WAIT: begin
                    if (out.read_data_valid) begin
                        state_q <= IDLE;
                    end else if (timeout_hit) begin
                        state_q   <= IDLE;
                        timeout_q <= 1'b1;
                    end else if (count_q != 8'hFF) begin
                        count_q <= count_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign timeout = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: the bench itself plays both leaders and the follower.
module tb_bus_arbiter;
    import bus_arbiter_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic accept0, accept1, timeout;
    int   vectors = 0;
    int   miscompares = 0;

    system_bus l0 ();
    system_bus l1 ();
    system_bus bo ();

    bus_arbiter #(.TimeoutCycles(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .leader0 (l0),
        .leader1 (l1),
        .out     (bo),
        .accept0 (accept0),
        .accept1 (accept1),
        .timeout (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_leaders;
        l0.addr = '0; l0.read_req = 1'b0; l0.write_req = 1'b0; l0.byte_enable = '0; l0.write_data = '0;
        l1.addr = '0; l1.read_req = 1'b0; l1.write_req = 1'b0; l1.byte_enable = '0; l1.write_data = '0;
    endtask

    task automatic cycle;
        @(negedge clk);
    endtask

    initial begin
        clear_leaders();
        bo.read_data = '0;
        bo.read_data_valid = 1'b0;

        // Reset state
        #2;
        check("rst_accept0", accept0, 0);
        check("rst_accept1", accept1, 0);
        check("rst_timeout", timeout, 0);
        check("rst_out_addr", bo.addr, 0);
        check("rst_out_wr", bo.write_req, 0);
        check("rst_out_rd", bo.read_req, 0);

        // Single write from leader0
        cycle(); reset = 1'b0;
        l0.addr = 32'h1000_0000; l0.write_req = 1'b1; l0.byte_enable = 4'h1; l0.write_data = 32'h5A;
        #1;
        check("w0_accept0", accept0, 1);
        check("w0_accept1", accept1, 0);
        check("w0_out_addr", bo.addr, 32'h1000_0000);
        check("w0_out_wr", bo.write_req, 1);
        check("w0_out_be", bo.byte_enable, 4'h1);
        check("w0_out_data", bo.write_data, 32'h5A);
        cycle(); clear_leaders();

        // Contention after reset: writes alternate 0,1,0,1,0,1
        reset = 1'b1; #1; reset = 1'b0;
        cycle();
        l0.addr = 32'hA000_0000; l0.write_req = 1'b1; l0.write_data = 32'h0A;
        l1.addr = 32'hB000_0000; l1.write_req = 1'b1; l1.write_data = 32'h0B;
        for (int i = 0; i < 6; i++) begin
            #1;
            check($sformatf("alt%0d_accept0", i), accept0, (i % 2 == 0) ? 1 : 0);
            check($sformatf("alt%0d_accept1", i), accept1, (i % 2 == 1) ? 1 : 0);
            check($sformatf("alt%0d_addr", i), bo.addr, (i % 2 == 0) ? 32'hA000_0000 : 32'hB000_0000);
            cycle();
        end
        clear_leaders();

        // Lone leader0 write so leader1 wins the next tie
        l0.addr = 32'h2000_0000; l0.write_req = 1'b1; l0.write_data = 32'h77;
        #1;
        check("solo_accept0", accept0, 1);
        cycle();

        // Leader1 reads ROM word 2 while leader0 holds a write
        l1.addr = 32'h0000_0008; l1.read_req = 1'b1;
        #1;
        check("rd_c0_accept1", accept1, 1);
        check("rd_c0_accept0", accept0, 0);
        check("rd_c0_out_rd", bo.read_req, 1);
        check("rd_c0_out_addr", bo.addr, 32'h0000_0008);
        cycle(); l1.addr = '0; l1.read_req = 1'b0;
        #1;
        check("rd_c1_accept0", accept0, 0);
        check("rd_c1_out_wr", bo.write_req, 0);
        check("rd_c1_l1_valid", l1.read_data_valid, 0);
        check("rd_c1_l0_valid", l0.read_data_valid, 0);
        cycle(); bo.read_data = 32'hC0DE_0002; bo.read_data_valid = 1'b1;
        #1;
        check("rd_c2_l1_data", l1.read_data, 32'hC0DE_0002);
        check("rd_c2_l1_valid", l1.read_data_valid, 1);
        check("rd_c2_l0_valid", l0.read_data_valid, 0);
        check("rd_c2_l0_data", l0.read_data, 0);
        check("rd_c2_accept0", accept0, 0);
        cycle(); bo.read_data = '0; bo.read_data_valid = 1'b0;
        #1;
        check("rd_c3_accept0", accept0, 1);
        check("rd_c3_out_data", bo.write_data, 32'h77);
        check("rd_c3_l1_valid", l1.read_data_valid, 0);
        cycle(); clear_leaders();

        // Read to an unmapped address times out after 4 wait cycles
        l0.addr = 32'hF000_0000; l0.read_req = 1'b1;
        #1;
        check("to_c0_accept0", accept0, 1);
        cycle(); clear_leaders();
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("to_c%0d_l0_valid", i), l0.read_data_valid, 0);
            check($sformatf("to_c%0d_timeout", i), timeout, 0);
            cycle();
        end
        #1;
        check("to_c4_l0_valid", l0.read_data_valid, 1);
        check("to_c4_l0_data", l0.read_data, 32'hDEAD_BEEF);
        check("to_c4_l1_valid", l1.read_data_valid, 0);
        check("to_c4_timeout", timeout, 0);
        cycle(); bo.read_data = 32'h1234_5678; bo.read_data_valid = 1'b1;
        #1;
        check("to_c5_timeout", timeout, 1);
        check("to_c5_late_l0_valid", l0.read_data_valid, 0);
        check("to_c5_late_l0_data", l0.read_data, 0);
        cycle(); bo.read_data = '0; bo.read_data_valid = 1'b0;
        #1;
        check("to_c6_timeout", timeout, 0);
        cycle();

        // Reset asserted during READ_WAIT
        l1.addr = 32'h0000_0004; l1.read_req = 1'b1;
        #1;
        check("rr_c0_accept1", accept1, 1);
        cycle(); clear_leaders();
        bo.read_data = 32'hAAAA_5555; bo.read_data_valid = 1'b1;
        #1;
        check("rr_pre_l1_valid", l1.read_data_valid, 1);
        reset = 1'b1;
        #1;
        check("rr_rst_l1_valid", l1.read_data_valid, 0);
        check("rr_rst_out_rd", bo.read_req, 0);
        check("rr_rst_accept1", accept1, 0);
        cycle(); reset = 1'b0;
        #1;
        check("rr_post_l1_valid", l1.read_data_valid, 0);
        cycle(); bo.read_data = '0; bo.read_data_valid = 1'b0;
        l0.write_req = 1'b1; l0.addr = 32'h3000_0000;
        l1.write_req = 1'b1; l1.addr = 32'h4000_0000;
        #1;
        check("rr_tie_accept0", accept0, 1);
        check("rr_tie_accept1", accept1, 0);
        check("rr_tie_addr", bo.addr, 32'h3000_0000);
        cycle(); clear_leaders();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
